// File: rtl/vga_timing_sequencer_if.sv
// VGA timing sequencer bus: the raster-advance / swap-request inputs and
// every registered timing output, bundled so the renderers, the negedge
// output stage and the game logic can share one connection.
// master : the timing sequencer itself (drives the raster outputs)
// slave  : a consumer / controller of the raster (drives en and swap_req)
interface vga_timing_sequencer_if;
    logic        en;
    logic        swap_req;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        blnk;
    logic        frame_start;
    logic        vblank_start;
    logic        swap_ack;
    logic        buf_sel;
    logic [23:0] rgb_out;

    modport master (
        input  en, swap_req,
        output hcount, vcount, hsync, vsync, blnk, frame_start,
               vblank_start, swap_ack, buf_sel, rgb_out
    );

    modport slave (
        output en, swap_req,
        input  hcount, vcount, hsync, vsync, blnk, frame_start,
               vblank_start, swap_ack, buf_sel, rgb_out
    );
endinterface

// File: rtl/vga_timing_sequencer.sv
// VGA raster generator and frame-buffer swap arbiter.
// All outputs are registered and decoded from the next-state counter values,
// so every flag describes the same pixel as the hcount/vcount shown with it.
// The very first enabled cycle after reset shows pixel (0,0) with frame_start.
// Optional feature: define VGA_TEST_PATTERN_EN to drive an 8-bar colour
// pattern on rgb_out; otherwise rgb_out is tied to zero.
module vga_timing_sequencer #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    vga_timing_sequencer_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACK
    } swap_state_t;

    swap_state_t state;
    swap_state_t next_state;

    logic        primed;
    logic        req_held;
    logic        req_eff;
    logic        ack_next;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        hsync_act;
    logic        vsync_act;
    logic        blank_next;
    logic        frame_next;
    logic        vblank_next;

    // Next raster position: the first enabled cycle after reset lands on
    // (0,0) instead of advancing, so frame_start is visible right away.
    always_comb begin
        h_next = vga.hcount;
        v_next = vga.vcount;
        if (!primed) begin
            h_next = '0;
            v_next = '0;
        end else if (vga.hcount == 11'(H_TOTAL - 1)) begin
            h_next = '0;
            if (vga.vcount == 11'(V_TOTAL - 1)) begin
                v_next = '0;
            end else begin
                v_next = vga.vcount + 11'd1;
            end
        end else begin
            h_next = vga.hcount + 11'd1;
        end
    end

    // Decode sync, blank and pulse flags from the next position.
    always_comb begin
        hsync_act   = (h_next >= 11'(H_ACTIVE + H_FP)) &&
                      (h_next <  11'(H_ACTIVE + H_FP + H_SYNC));
        vsync_act   = (v_next >= 11'(V_ACTIVE + V_FP)) &&
                      (v_next <  11'(V_ACTIVE + V_FP + V_SYNC));
        blank_next  = (h_next >= 11'(H_ACTIVE)) || (v_next >= 11'(V_ACTIVE));
        frame_next  = (h_next == 11'd0) && (v_next == 11'd0);
        vblank_next = (h_next == 11'd0) && (v_next == 11'(V_ACTIVE));
    end

    // Swap FSM next state: a request moves IDLE to PENDING, PENDING waits for
    // a cycle that shows vblank_start, ACK lasts one cycle. A pulse seen
    // while frozen is remembered in req_held and acted on once en returns.
    always_comb begin
        next_state = state;
        ack_next   = 1'b0;
        req_eff    = vga.swap_req | req_held;
        case (state)
            IDLE: begin
                if (req_eff) next_state = PENDING;
            end
            PENDING: begin
                if (vga.vblank_start) next_state = ACK;
            end
            ACK: begin
                next_state = req_eff ? PENDING : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        ack_next = (next_state == ACK);
    end

    // Swap FSM state register; reset discards any pending swap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (vga.en) begin
            state <= next_state;
        end
    end

    // Raster counters, registered timing outputs and the front-buffer select.
    always_ff @(posedge clk) begin
        if (!rst) begin
            primed           <= 1'b0;
            req_held         <= 1'b0;
            vga.hcount       <= '0;
            vga.vcount       <= '0;
            vga.hsync        <= ~SYNC_POL;
            vga.vsync        <= ~SYNC_POL;
            vga.blnk         <= 1'b0;
            vga.frame_start  <= 1'b0;
            vga.vblank_start <= 1'b0;
            vga.swap_ack     <= 1'b0;
            vga.buf_sel      <= 1'b0;
        end else if (vga.en) begin
            primed           <= 1'b1;
            req_held         <= 1'b0;
            vga.hcount       <= h_next;
            vga.vcount       <= v_next;
            vga.hsync        <= hsync_act ? SYNC_POL : ~SYNC_POL;
            vga.vsync        <= vsync_act ? SYNC_POL : ~SYNC_POL;
            vga.blnk         <= blank_next;
            vga.frame_start  <= frame_next;
            vga.vblank_start <= vblank_next;
            vga.swap_ack     <= ack_next;
            vga.buf_sel      <= vga.buf_sel ^ ack_next;
        end else if (vga.swap_req) begin
            req_held <= 1'b1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_idx;
    logic [23:0] rgb_next;

    // Colour-bar lookup for the next pixel; black whenever it is blanked.
    always_comb begin
        rgb_next = '0;
        bar_idx  = 3'(h_next / 11'(BAR_W));
        if (!blank_next) begin
            case (bar_idx)
                3'd0:    rgb_next = 24'hFFFFFF;
                3'd1:    rgb_next = 24'hFFFF00;
                3'd2:    rgb_next = 24'h00FFFF;
                3'd3:    rgb_next = 24'h00FF00;
                3'd4:    rgb_next = 24'hFF00FF;
                3'd5:    rgb_next = 24'hFF0000;
                3'd6:    rgb_next = 24'h0000FF;
                default: rgb_next = 24'h000000;
            endcase
        end
    end

    // Register the pattern alongside the counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vga.rgb_out <= '0;
        end else if (vga.en) begin
            vga.rgb_out <= rgb_next;
        end
    end
`else
    assign vga.rgb_out = '0;
`endif

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Directed bench for vga_timing_sequencer using a shrunken raster
// (24 clocks x 12 lines) so several whole frames fit in a short run.
// A linear position counter in the bench predicts hcount/vcount.
module tb_vga_timing_sequencer;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk;
    logic rst;
    int   pos;
    int   checks;
    int   errors;
    int   ack_count;

    vga_timing_sequencer_if bus ();

    vga_timing_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(bus.master)
    );

    // Free-running pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs settle 1 time unit after the edge. The position
    // model advances only on enabled, non-reset edges.
    task automatic apply_stimulus();
        logic adv;
        logic in_rst;
        adv    = bus.en && rst;
        in_rst = !rst;
        @(posedge clk);
        #1;
        if (in_rst) pos = -1;
        else if (adv) pos++;
        if (bus.swap_ack === 1'b1) ack_count++;
    endtask

    // Run to a raster position in a given frame and confirm the counters.
    task automatic advance_to(input int frame, input int h, input int v);
        int target;
        int guard;
        target = frame * FRAME + v * HT + h;
        guard  = 0;
        while (pos < target && guard < 4 * FRAME) begin
            apply_stimulus();
            guard++;
        end
        check_output($sformatf("pos f%0d (%0d,%0d) hcount", frame, h, v), 32'(bus.hcount), 32'(pos % HT));
        check_output($sformatf("pos f%0d (%0d,%0d) vcount", frame, h, v), 32'(bus.vcount), 32'((pos / HT) % VT));
    endtask

    // One-cycle swap request at the current position.
    task automatic pulse_req();
        bus.swap_req = 1'b1;
        apply_stimulus();
        bus.swap_req = 1'b0;
    endtask

    function automatic logic [23:0] exp_rgb(input logic [23:0] pattern);
`ifdef VGA_TEST_PATTERN_EN
        return pattern;
`else
        return 24'h0 & pattern;
`endif
    endfunction

    // Directed sequence: reset, line/frame timing, swaps, freeze, reset mid-swap.
    initial begin
        logic [10:0] h_hold;
        logic [10:0] v_hold;
        checks       = 0;
        errors       = 0;
        ack_count    = 0;
        pos          = -1;
        rst          = 1'b0;
        bus.en       = 1'b1;
        bus.swap_req = 1'b0;

        repeat (5) apply_stimulus();
        check_output("rst hcount", 32'(bus.hcount), 32'd0);
        check_output("rst vcount", 32'(bus.vcount), 32'd0);
        check_output("rst frame_start", 32'(bus.frame_start), 32'd0);
        check_output("rst blnk", 32'(bus.blnk), 32'd0);
        check_output("rst hsync", 32'(bus.hsync), 32'd0);
        check_output("rst vsync", 32'(bus.vsync), 32'd0);
        check_output("rst buf_sel", 32'(bus.buf_sel), 32'd0);
        check_output("rst swap_ack", 32'(bus.swap_ack), 32'd0);
        check_output("rst rgb", 32'(bus.rgb_out), 32'd0);

        rst = 1'b1;
        apply_stimulus();
        check_output("start hcount", 32'(bus.hcount), 32'd0);
        check_output("start vcount", 32'(bus.vcount), 32'd0);
        check_output("start frame_start", 32'(bus.frame_start), 32'd1);
        check_output("start hsync", 32'(bus.hsync), 32'd0);
        check_output("start vsync", 32'(bus.vsync), 32'd0);
        check_output("start blnk", 32'(bus.blnk), 32'd0);
        apply_stimulus();
        check_output("pix1 hcount", 32'(bus.hcount), 32'd1);
        check_output("pix1 frame_start", 32'(bus.frame_start), 32'd0);

        // Line timing
        advance_to(0, 15, 0); check_output("h15 blnk", 32'(bus.blnk), 32'd0);
        advance_to(0, 16, 0); check_output("h16 blnk", 32'(bus.blnk), 32'd1);
        advance_to(0, 17, 0); check_output("h17 hsync", 32'(bus.hsync), 32'd0);
        advance_to(0, 18, 0); check_output("h18 hsync", 32'(bus.hsync), 32'd1);
        advance_to(0, 20, 0); check_output("h20 hsync", 32'(bus.hsync), 32'd1);
        advance_to(0, 21, 0); check_output("h21 hsync", 32'(bus.hsync), 32'd0);
        advance_to(0, 23, 0);
        apply_stimulus();
        check_output("wrap hcount", 32'(bus.hcount), 32'd0);
        check_output("wrap vcount", 32'(bus.vcount), 32'd1);

        // Test pattern on an active line
        advance_to(0, 0, 2);  check_output("rgb h0",  32'(bus.rgb_out), 32'(exp_rgb(24'hFFFFFF)));
        advance_to(0, 2, 2);  check_output("rgb h2",  32'(bus.rgb_out), 32'(exp_rgb(24'hFFFF00)));
        advance_to(0, 10, 2); check_output("rgb h10", 32'(bus.rgb_out), 32'(exp_rgb(24'hFF0000)));
        advance_to(0, 15, 2); check_output("rgb h15", 32'(bus.rgb_out), 32'd0);
        advance_to(0, 16, 2); check_output("rgb h16", 32'(bus.rgb_out), 32'd0);

        // Frame timing
        advance_to(0, 0, 8);
        check_output("v8 vblank_start", 32'(bus.vblank_start), 32'd1);
        check_output("v8 blnk", 32'(bus.blnk), 32'd1);
        check_output("v8 vsync", 32'(bus.vsync), 32'd0);
        advance_to(0, 1, 8);  check_output("v8h1 vblank_start", 32'(bus.vblank_start), 32'd0);
        advance_to(0, 23, 8); check_output("v8h23 vsync", 32'(bus.vsync), 32'd0);
        advance_to(0, 0, 9);  check_output("v9 vsync", 32'(bus.vsync), 32'd1);
        advance_to(0, 23, 10); check_output("v10h23 vsync", 32'(bus.vsync), 32'd1);
        advance_to(0, 0, 11); check_output("v11 vsync", 32'(bus.vsync), 32'd0);
        advance_to(1, 0, 0);  check_output("frame1 frame_start", 32'(bus.frame_start), 32'd1);
        check_output("no ack frame0", 32'(ack_count), 32'd0);

        // Three requests in one frame yield a single ack after vblank_start
        advance_to(2, 0, 3); pulse_req();
        advance_to(2, 5, 4); pulse_req();
        advance_to(2, 5, 6); pulse_req();
        advance_to(2, 0, 8);
        check_output("swap vblank ack", 32'(bus.swap_ack), 32'd0);
        check_output("swap vblank buf", 32'(bus.buf_sel), 32'd0);
        advance_to(2, 1, 8);
        check_output("swap ack", 32'(bus.swap_ack), 32'd1);
        check_output("swap buf", 32'(bus.buf_sel), 32'd1);
        advance_to(2, 2, 8);
        check_output("swap ack drop", 32'(bus.swap_ack), 32'd0);
        ack_count = 0;
        advance_to(4, 0, 0);
        check_output("single ack count", 32'(ack_count), 32'd0);
        check_output("single ack buf", 32'(bus.buf_sel), 32'd1);

        // Request on the vblank_start cycle waits a full frame
        advance_to(4, 0, 8); pulse_req();
        check_output("late req ack", 32'(bus.swap_ack), 32'd0);
        check_output("late req buf", 32'(bus.buf_sel), 32'd1);
        advance_to(5, 1, 8);
        check_output("deferred ack", 32'(bus.swap_ack), 32'd1);
        check_output("deferred buf", 32'(bus.buf_sel), 32'd0);

        // Freeze mid-line for 50 cycles
        advance_to(6, 10, 2);
        h_hold = bus.hcount;
        v_hold = bus.vcount;
        bus.en = 1'b0;
        repeat (50) apply_stimulus();
        check_output("freeze hcount", 32'(bus.hcount), 32'd10);
        check_output("freeze vcount", 32'(bus.vcount), 32'd2);
        check_output("freeze blnk", 32'(bus.blnk), 32'd0);
        check_output("freeze rgb", 32'(bus.rgb_out), 32'(exp_rgb(24'hFF0000)));
        bus.en = 1'b1;
        apply_stimulus();
        check_output("resume hcount", 32'(bus.hcount), 32'(h_hold + 11'd1));
        check_output("resume vcount", 32'(bus.vcount), 32'(v_hold));

        // Freeze while a pulse is shown: it must stay high
        advance_to(7, 0, 0);
        bus.en = 1'b0;
        repeat (10) apply_stimulus();
        check_output("freeze frame_start", 32'(bus.frame_start), 32'd1);
        bus.en = 1'b1;
        apply_stimulus();
        check_output("unfreeze frame_start", 32'(bus.frame_start), 32'd0);

        // Reset while PENDING drops the swap
        advance_to(7, 0, 3); pulse_req();
        advance_to(7, 5, 5);
        rst = 1'b0;
        repeat (3) apply_stimulus();
        check_output("midrst buf", 32'(bus.buf_sel), 32'd0);
        rst = 1'b1;
        ack_count = 0;
        advance_to(2, 0, 0);
        check_output("midrst ack count", 32'(ack_count), 32'd0);
        check_output("midrst buf after", 32'(bus.buf_sel), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/vga_timing_sequencer.md
Name: vga_timing_sequencer

Overview:
Generates the VGA raster for the display pipeline: pixel counters, hsync, vsync and blank, all registered and mutually aligned. It sequences the downstream sprite/background renderers and the negedge output stage. It also arbitrates the frame-buffer swap, so the game logic swaps buffers only at vertical-blank start, never mid-frame.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, hsync pulse width
H_BP, 88, horizontal back porch
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync pulse width
V_BP, 23, vertical back porch
SYNC_POL, 1, 1 = sync pulses active-high, 0 = active-low

Ports:
clk  in  1  pixel clock (40 MHz for defaults)
rst  in  1  synchronous reset, active-low
en  in  1  advance raster; 0 freezes all counters, outputs and FSM
swap_req  in  1  single-cycle request for a frame-buffer swap
hcount  out  11  current pixel column, 0..H_TOTAL-1
vcount  out  11  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
blnk  out  1  1 outside the active area
frame_start  out  1  1-cycle pulse when hcount=0 and vcount=0
vblank_start  out  1  1-cycle pulse when hcount=0 and vcount=V_ACTIVE
swap_ack  out  1  1-cycle pulse when the swap is performed
buf_sel  out  1  front-buffer index; toggles on each swap_ack
rgb_out  out  24  test-pattern colour (see Optional Feature)

Behaviour:
- Sums: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056 by default); V_TOTAL likewise (628 by default).
- Reset (rst=0 at a clk edge) sets:
  - hcount=0, vcount=0, blnk=0, buf_sel=0, rgb_out=0;
  - hsync and vsync at their inactive level (= !SYNC_POL);
  - frame_start=0, vblank_start=0, swap_ack=0;
  - swap FSM to IDLE.
- Reset mid-frame or mid-handshake discards any pending swap. The first cycle after reset release shows hcount=0/vcount=0, and frame_start is asserted on that cycle.
- Counters, when en=1:
  - hcount increments each clock and wraps H_TOTAL-1 -> 0.
  - vcount increments only on the hcount wrap and wraps V_TOTAL-1 -> 0 on the same edge.
  - en=0 holds every output, including pulses, at its current value.
- All outputs are registered and decoded from next-state counter values, so they are valid on the same cycle as the hcount/vcount they describe (zero relative latency).
- hsync is active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync is active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; it changes only on hcount=0 boundaries.
- blnk = (hcount >= H_ACTIVE) | (vcount >= V_ACTIVE).
- Swap FSM (3 states, advances only when en=1):
  - IDLE: swap_req=1 -> PENDING.
  - PENDING: next vblank_start cycle -> ACK. Further swap_req pulses are absorbed and do not queue a second swap.
  - ACK: swap_ack=1 for exactly one cycle and buf_sel toggles on the same edge; then -> IDLE. A swap_req during ACK -> PENDING, which is serviced at the following frame's vblank_start.
  - A request arriving on the vblank_start cycle itself, while IDLE, waits for the next frame.
  - A request arriving during vblank waits for the next vblank_start; no late swap.
- swap_req is sampled while en=0 but has no effect on state until en returns to 1.

Optional Feature:
Macro: VGA_TEST_PATTERN_EN.
- Defined: rgb_out is a registered 8-bar colour pattern, aligned with the counters. Bar index = hcount / (H_ACTIVE/8). Colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. rgb_out=0 whenever blnk=1.
- Not defined: rgb_out is constant 0 and no pattern logic is synthesised.

Test Plan:
- Reset/start: hold rst=0 for 5 clk, release with en=1 -> first cycle hcount=0, vcount=0, frame_start=1, hsync=vsync=0 (SYNC_POL=1), buf_sel=0.
- Line timing, defaults: hsync rises at hcount=840 and falls at hcount=968; blnk rises at hcount=800; hcount 1055 -> 0 while vcount increments by 1.
- Frame timing: vsync is high for vcount 601..604; vblank_start pulses once at vcount=600, hcount=0; frame_start recurs every 1056*628 = 663168 clocks.
- Swap: pulse swap_req at vcount=100 -> swap_ack pulses on the cycle after vblank_start at vcount=600; buf_sel 0 -> 1; exactly one ack per frame even with 3 swap_req pulses in one frame.
- Freeze/reset mid-op: en=0 for 50 cycles at hcount=500 -> all outputs stable, resume at hcount=501. rst=0 while PENDING -> no swap_ack ever issued, buf_sel=0.
- With VGA_TEST_PATTERN_EN at vcount=10: hcount=0 -> FFFFFF, 100 -> FFFF00, 799 -> 000000, 800 -> 000000 (blank); without the macro rgb_out=0 throughout.
